// File: rtl/imem_loader_ctrl.sv
// Boot loader for the instruction memory: streams host bytes into words, then releases the core.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader_ctrl #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW:0]      len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic [31:0]      pc,
  output logic [AW-1:0]    mem_a,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wd,
  output logic             core_rst_n,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RUN
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t      state;
  logic [AW:0] ptr;
  logic [AW:0] len_q;
  logic [1:0]  k;
  logic [23:0] asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  logic        take;
  logic [AW:0] ptr_nx;
  logic [31:0] word_nx;
  logic        unused_pc;

  assign take      = byte_valid && byte_ready;
  assign ptr_nx    = ptr + (AW+1)'(1);
  // The top byte is never stored; the completed word is formed from the live byte.
  assign word_nx   = {byte_data, asm_q};
  assign unused_pc = ^pc[31:AW+2];

  always_comb begin
    mem_a = '0;
    if (state == WRITE)
      mem_a = ptr[AW-1:0];
    else if (state == RUN && core_rst_n)
      mem_a = pc[AW+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      core_rst_n <= 1'b0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_wd     <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      ptr        <= '0;
      len_q      <= '0;
      k          <= '0;
      asm_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else if (start && (state == IDLE || state == RUN)) begin
      core_rst_n <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      if (len > DEPTH_W) begin
        err   <= 1'b1;
        state <= IDLE;
      end else if (len == '0) begin
        err <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum        <= '0;
        k          <= '0;
        byte_ready <= 1'b1;
        busy       <= 1'b1;
        state      <= CHECK;
`else
        // From RUN this gives the core a one-cycle reset pulse before it restarts.
        core_rst_n <= (state == IDLE);
        state      <= RUN;
`endif
      end else begin
        err        <= 1'b0;
        len_q      <= len;
        ptr        <= '0;
        k          <= '0;
        byte_ready <= 1'b1;
        busy       <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum        <= '0;
`endif
        state      <= LOAD;
      end
    end else begin
      if (take) begin
        k <= k + 2'd1;
        case (k)
          2'd0:    asm_q[7:0]   <= byte_data;
          2'd1:    asm_q[15:8]  <= byte_data;
          2'd2:    asm_q[23:16] <= byte_data;
          default: ;
        endcase
      end
      case (state)
        IDLE: core_rst_n <= 1'b0;
        LOAD: begin
          if (take && k == 2'd3) begin
            mem_we     <= 1'b1;
            mem_wd     <= word_nx;
            byte_ready <= 1'b0;
            state      <= WRITE;
          end
        end
        WRITE: begin
          mem_we <= 1'b0;
          ptr    <= ptr_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum    <= sum + mem_wd;
`endif
          if (ptr_nx == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            byte_ready <= 1'b1;
            state      <= CHECK;
`else
            busy       <= 1'b0;
            core_rst_n <= 1'b1;
            state      <= RUN;
`endif
          end else begin
            byte_ready <= 1'b1;
            state      <= LOAD;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (take && k == 2'd3) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (word_nx == sum) begin
              core_rst_n <= 1'b1;
              state      <= RUN;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
`endif
        RUN: begin
          core_rst_n <= 1'b1;
          if (core_rst_n && pc[1:0] != 2'b00)
            err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Scoreboarded bench for imem_loader_ctrl: memory writes are checked by a monitor against a queue.
module tb_imem_loader_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic [31:0]   pc = '0;
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic          core_rst_n;
  logic          busy;
  logic          err;

  imem_loader_ctrl #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .pc(pc), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
    .core_rst_n(core_rst_n), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_count = 0;
  bit  busy_watch = 0;
  bit  busy_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", mem_a, mem_wd);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_a), 32'(e.addr));
        check("write_data", mem_wd, e.data);
      end
    end
    if (busy_watch && !busy) busy_drop = 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input int unsigned l);
    len   = (AW+1)'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int unsigned n = 0;
    if (gap) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      tick();
      n++;
    end
    if (!byte_ready) begin
      check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    end else begin
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w, input bit gap);
    logic [31:0] v;
    wr_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    v = w;
    for (int unsigned i = 0; i < 4; i++) send_byte(v[8*i +: 8], gap);
  endtask

  // Checksum trailer only exists in the checksum build.
  task automatic send_sum(input logic [31:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] v;
    v = s;
    for (int unsigned i = 0; i < 4; i++) send_byte(v[8*i +: 8], 1'b0);
`else
    if (s == 32'hFFFF_FFFF) $display("note: checksum %h unused", s);
`endif
  endtask

  initial begin
    int w0;

    // Reset state
    tick();
    check("rst_core_rst_n", 32'(core_rst_n), 0);
    check("rst_byte_ready", 32'(byte_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_wd", mem_wd, 0);
    rst_n = 1'b1;
    tick();

    // Single word load, then core runs and fetches via pc
    pc = 32'h4;
    pulse_start(1);
    check("load_byte_ready", 32'(byte_ready), 1);
    check("load_busy", 32'(busy), 1);
    check("load_mem_a_not_pc", 32'(mem_a), 0);
    send_word(8'd0, 32'h0070_0093, 1'b0);
    check("write_mem_we", 32'(mem_we), 1);
    check("write_core_held", 32'(core_rst_n), 0);
    tick();
    send_sum(32'h0070_0093);
    check("run_core_rst_n", 32'(core_rst_n), 1);
    check("run_busy", 32'(busy), 0);
    check("run_mem_a_pc", 32'(mem_a), 1);
    pc = 32'h0;

    // Three words with byte_valid toggling every other cycle
    w0 = wr_count;
    pulse_start(3);
    busy_watch = 1;
    busy_drop  = 0;
    send_word(8'd0, 32'h0010_0113, 1'b1);
    send_word(8'd1, 32'h0010_0193, 1'b1);
    send_word(8'd2, 32'h0000_0013, 1'b1);
    tick();
    busy_watch = 0;
    send_sum(32'h0020_02B9);
    check("multi_busy_held", 32'(busy_drop), 0);
    check("multi_busy_drop", 32'(busy), 0);
    check("multi_core_run", 32'(core_rst_n), 1);
    check("multi_write_count", 32'(wr_count - w0), 3);

    // len beyond DEPTH is rejected
    do_reset();
    w0 = wr_count;
    pulse_start(257);
    tick();
    check("big_err", 32'(err), 1);
    check("big_core_held", 32'(core_rst_n), 0);
    check("big_byte_ready", 32'(byte_ready), 0);
    check("big_busy", 32'(busy), 0);
    check("big_no_write", 32'(wr_count - w0), 0);
    pulse_start(1);
    check("restart_err_clear", 32'(err), 0);
    check("restart_byte_ready", 32'(byte_ready), 1);

    // Asynchronous reset two bytes into word 0
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_byte_ready", 32'(byte_ready), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_core", 32'(core_rst_n), 0);
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_mem_a", 32'(mem_a), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("abort_no_write", 32'(wr_count - w0), 0);

`ifndef IMEM_LOADER_CHECKSUM_EN
    // Empty program goes straight to RUN
    pulse_start(0);
    check("len0_core_run", 32'(core_rst_n), 1);
    check("len0_busy", 32'(busy), 0);
`endif

    // Misaligned pc in RUN, then restart from RUN
    do_reset();
    pulse_start(1);
    send_word(8'd0, 32'h0070_0093, 1'b0);
    tick();
    send_sum(32'h0070_0093);
    pc = 32'h6;
    tick();
    check("misalign_err", 32'(err), 1);
    check("misalign_core_runs", 32'(core_rst_n), 1);
    pc = 32'h0;
    pulse_start(1);
    check("rerun_core_held", 32'(core_rst_n), 0);
    check("rerun_byte_ready", 32'(byte_ready), 1);
    check("rerun_err_clear", 32'(err), 0);
    send_word(8'd0, 32'h0000_0013, 1'b0);
    tick();
    send_sum(32'h0000_0013);
    check("rerun_core_run", 32'(core_rst_n), 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    pulse_start(2);
    send_word(8'd0, 32'h1, 1'b0);
    send_word(8'd1, 32'h2, 1'b0);
    tick();
    send_sum(32'h3);
    check("sum_ok_core", 32'(core_rst_n), 1);
    check("sum_ok_err", 32'(err), 0);
    pulse_start(2);
    send_word(8'd0, 32'h1, 1'b0);
    send_word(8'd1, 32'h2, 1'b0);
    tick();
    send_sum(32'h4);
    check("sum_bad_err", 32'(err), 1);
    check("sum_bad_core", 32'(core_rst_n), 0);
    tick();
    check("sum_bad_core_held", 32'(core_rst_n), 0);
    check("sum_bad_busy", 32'(busy), 0);
`endif

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
